// File: rtl/procyon_ifq.sv
// rtl/procyon_ifq.sv - instruction fetch miss queue with single-outstanding line fill
//
// Purpose:
//   Holds instruction-cache miss line addresses in a circular queue, issues them
//   one at a time to memory as line reads, and returns each line as a one-cycle
//   fill. Misses to a line already held in the queue are merged. A fetch redirect
//   discards entries that have not been issued yet. The issued entry always
//   completes and produces its fill.
//
// Ports:
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-high reset
//   i_flush          in   fetch redirect, drops unissued entries
//   i_alloc_en       in   miss allocation request
//   i_alloc_addr     in   miss byte address
//   o_ifq_full       out  queue holds OPTN_IFQ_DEPTH entries, allocations dropped
//   o_mem_req_valid  out  line read request valid
//   o_mem_req_addr   out  line-aligned request address
//   i_mem_req_ready  in   memory accepts the request
//   i_mem_rsp_valid  in   line data for the outstanding request
//   i_mem_rsp_data   in   returned line
//   o_fill_en        out  one-cycle fill strobe
//   o_fill_addr      out  filled line address, held between fills
//   o_fill_data      out  filled line data, held between fills

module procyon_ifq #(
  parameter int OPTN_ADDR_WIDTH   = 32,
  parameter int OPTN_IC_LINE_SIZE = 32,
  parameter int OPTN_IFQ_DEPTH    = 4,
  parameter int IC_LINE_WIDTH     = OPTN_IC_LINE_SIZE * 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_alloc_en,
  input  logic [OPTN_ADDR_WIDTH-1:0] i_alloc_addr,
  output logic                       o_ifq_full,
  output logic                       o_mem_req_valid,
  output logic [OPTN_ADDR_WIDTH-1:0] o_mem_req_addr,
  input  logic                       i_mem_req_ready,
  input  logic                       i_mem_rsp_valid,
  input  logic [IC_LINE_WIDTH-1:0]   i_mem_rsp_data,
  output logic                       o_fill_en,
  output logic [OPTN_ADDR_WIDTH-1:0] o_fill_addr,
  output logic [IC_LINE_WIDTH-1:0]   o_fill_data
);

  localparam int PTR_W = $clog2(OPTN_IFQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0]           PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]           CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]           CNT_FULL  = CNT_W'(OPTN_IFQ_DEPTH);
  localparam logic [OPTN_ADDR_WIDTH-1:0] OFF_MASK  = OPTN_ADDR_WIDTH'(OPTN_IC_LINE_SIZE - 1);
  localparam logic [OPTN_ADDR_WIDTH-1:0] LINE_MASK = ~OFF_MASK;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [PTR_W-1:0]             r_head;
  logic [PTR_W-1:0]             r_tail;
  logic [CNT_W-1:0]             r_count;
  logic [OPTN_IFQ_DEPTH-1:0]    r_valid;
  logic [OPTN_ADDR_WIDTH-1:0]   r_addr [OPTN_IFQ_DEPTH];

  logic                         r_fill_en;
  logic [OPTN_ADDR_WIDTH-1:0]   r_fill_addr;
  logic [IC_LINE_WIDTH-1:0]     r_fill_data;

  logic [OPTN_ADDR_WIDTH-1:0]   w_line_addr;
  logic                         w_match;
  logic                         w_full;
  logic                         w_alloc;
  logic                         w_retire;
  logic                         w_issued;
  logic                         w_mem_req_valid;
  logic [PTR_W-1:0]             w_head_nxt;
  logic [PTR_W-1:0]             w_tail_nxt;
  logic [CNT_W-1:0]             w_count_nxt;
  logic [OPTN_IFQ_DEPTH-1:0]    w_valid_nxt;

  assign w_line_addr = i_alloc_addr & LINE_MASK;
  assign w_full      = (r_count == CNT_FULL);
  // The head entry is the issued one whenever the FSM has left IDLE.
  assign w_issued    = (r_state != IDLE);
  assign w_retire    = (r_state == WAIT_RSP) && i_mem_rsp_valid;
  // Full is taken from registered count, so a retirement this cycle cannot free room.
  assign w_alloc     = i_alloc_en && !w_full && !i_flush && !w_match;

  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < OPTN_IFQ_DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == w_line_addr)) begin
        w_match = 1'b1;
      end
    end
  end

  // Queue bookkeeping. Flush keeps only the issued head entry, and that one
  // disappears too when its response arrives in the same cycle.
  always_comb begin
    w_valid_nxt = r_valid;
    w_head_nxt  = w_retire ? (r_head + PTR_ONE) : r_head;
    w_tail_nxt  = w_alloc ? (r_tail + PTR_ONE) : r_tail;
    w_count_nxt = r_count;

    if (w_retire) begin
      w_valid_nxt[r_head] = 1'b0;
    end
    if (w_alloc) begin
      w_valid_nxt[r_tail] = 1'b1;
    end

    case ({w_alloc, w_retire})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase

    if (i_flush) begin
      w_valid_nxt = '0;
      if (w_issued) begin
        w_tail_nxt = r_head + PTR_ONE;
        if (!w_retire) begin
          w_valid_nxt[r_head] = 1'b1;
          w_count_nxt         = CNT_ONE;
        end else begin
          w_count_nxt = '0;
        end
      end else begin
        w_tail_nxt  = r_head;
        w_count_nxt = '0;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_valid = 1'b0;
    case (r_state)
      IDLE: begin
        // A flush in IDLE empties the queue, so there is nothing to issue.
        if ((r_count != '0) && !i_flush) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        w_mem_req_valid = 1'b1;
        if (i_mem_req_ready) begin
          w_state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (i_mem_rsp_valid) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < OPTN_IFQ_DEPTH; i++) begin
        r_addr[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      r_valid <= w_valid_nxt;
      if (w_alloc) begin
        r_addr[r_tail] <= w_line_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_en   <= 1'b0;
      r_fill_addr <= '0;
      r_fill_data <= '0;
    end else begin
      r_fill_en <= w_retire;
      if (w_retire) begin
        r_fill_addr <= r_addr[r_head];
        r_fill_data <= i_mem_rsp_data;
      end
    end
  end

  assign o_ifq_full      = w_full;
  assign o_mem_req_valid = w_mem_req_valid;
  assign o_mem_req_addr  = r_addr[r_head];
  assign o_fill_en       = r_fill_en;
  assign o_fill_addr     = r_fill_addr;
  assign o_fill_data     = r_fill_data;

endmodule
